fp_tanh_feeder: RTL and testbench

//  Buffers a stream of IEEE-754 double activations (e.g. neuron sums) and issues them
//  one at a time to the fp_tanh unit through its start/done handshake. Results are

---
 rtl/fp_tanh_feeder.sv | 146 ++++++++++++++
 tb/tb_fp_tanh_feeder.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_tanh_feeder.sv
// fp_tanh_feeder
//   Queues IEEE-754 double operands in a small FIFO and feeds them one at a
//   time to an fp_tanh unit over its start/done handshake, then presents each
//   result (with the operand's last flag) on a valid/ready output stream.
//   Operand and result bits pass through untouched; ordering is strict FIFO.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid/in_ready      input stream handshake; in_ready = FIFO not full
//   in_data/in_last        operand and its end-of-vector flag
//   out_valid/out_ready    output stream handshake
//   out_data/out_last      tanh result and the matching operand's last flag
//   tanh_in/tanh_start     operand and one-cycle start pulse to fp_tanh
//   tanh_out/tanh_done     result and completion from fp_tanh
//   busy                   operand in flight, FIFO occupied or result pending
//   fifo_count             current FIFO occupancy
module fp_tanh_feeder #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_last,
    output logic [DATA_W-1:0]      tanh_in,
    output logic                   tanh_start,
    input  logic [DATA_W-1:0]      tanh_out,
    input  logic                   tanh_done,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } entry_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          load;
    logic          last_q;
    state_t        state;
    state_t        state_nx;

    // Ready comes from the registered count only, so a pop in the same cycle
    // never opens the input to a push.
    assign full       = (count == FULL_CNT);
    assign empty      = (count == '0);
    assign in_ready   = !full;
    assign push       = in_valid && !full;
    assign pop        = (state == ISSUE);
    assign head       = mem[rd_ptr];
    assign fifo_count = count;
    // The operand has to be on tanh_in during the start cycle, so it is
    // captured on the edge that enters ISSUE; the pop follows at the end of ISSUE.
    assign load       = (state_nx == ISSUE);

    // ---------------- FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_last, in_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (!empty && !out_valid) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (tanh_done) state_nx = HOLD;
            HOLD:    if (out_valid && out_ready) state_nx = empty ? IDLE : ISSUE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        tanh_start = (state == ISSUE);
        busy       = (state != IDLE) || !empty;
    end

    // ---------------- operand / result registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tanh_in   <= '0;
            last_q    <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                tanh_in <= head.data;
                last_q  <= head.last;
            end
            // done is only honoured while waiting; stray or stretched pulses
            // in any other state leave the result register alone.
            if (state == WAIT && tanh_done) begin
                out_data  <= tanh_out;
                out_last  <= last_q;
                out_valid <= 1'b1;
            end else if (state == HOLD && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fp_tanh_feeder.sv
module tb_fp_tanh_feeder;

    localparam int DEPTH  = 8;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid, in_ready, in_last;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready, out_last;
    logic [DATA_W-1:0] out_data;
    logic [DATA_W-1:0] tanh_in, tanh_out;
    logic              tanh_start, tanh_done;
    logic              busy;
    logic [$clog2(DEPTH):0] fifo_count;

    fp_tanh_feeder #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .tanh_in(tanh_in), .tanh_start(tanh_start), .tanh_out(tanh_out), .tanh_done(tanh_done),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got 0x%h expected 0x%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_real(input string name, input logic [63:0] bits, input real exp);
        real act;
        act = $bitstoreal(bits);
        total++;
        if (act - exp > 1e-9 || exp - act > 1e-9) begin
            bad++;
            $display("FAIL %s: got %.10f expected %.10f", name, act, exp);
        end
    endtask

    // ---------------- reference tanh ----------------
    function automatic real th(input real x);
        real e;
        if (x > 20.0)  return 1.0;
        if (x < -20.0) return -1.0;
        e = $exp(2.0 * x);
        return (e - 1.0) / (e + 1.0);
    endfunction

    // NaN and +/-0 come back bit-for-bit, everything else is tanh(x).
    function automatic logic [63:0] tanh_bits(input logic [63:0] b);
        real x;
        x = $bitstoreal(b);
        if (x != x)   return b;
        if (x == 0.0) return b;
        return $realtobits(th(x));
    endfunction

    function automatic logic [63:0] rand_operand();
        logic [63:0] sp [6];
        sp = '{64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h7ff0_0000_0000_0000,
               64'hfff0_0000_0000_0000, 64'h7ff8_0000_0000_0001, 64'h3ff0_0000_0000_0000};
        case ($urandom_range(0, 4))
            0:       return sp[$urandom_range(0, 5)];
            1:       return {$urandom, $urandom};
            default: return $realtobits((real'($urandom_range(0, 8000)) - 4000.0) / 1000.0);
        endcase
    endfunction

    // ---------------- behavioural fp_tanh ----------------
    logic        inflight = 1'b0;
    logic        real_done = 1'b0;
    logic [63:0] op;
    int          lat;
    int          extra = 0;
    int          force_lat = 0;
    int          n_starts = 0;
    int          last_start_cyc = -1;

    initial begin
        tanh_done = 1'b0;
        tanh_out  = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inflight = 1'b0;
            end else if (tanh_start) begin
                chk("one_in_flight", !inflight, 64'(inflight), 64'd0);
                inflight = 1'b1;
                op = tanh_in;
                lat = (force_lat != 0) ? force_lat : int'($urandom_range(1, 4));
                n_starts++;
                last_start_cyc = cyc;
            end else if (inflight) begin
                chk("tanh_in_stable", tanh_in == op, tanh_in, op);
            end
            @(posedge clk); #1;
            tanh_done = 1'b0;
            real_done = 1'b0;
            if (!rst_n) begin
                inflight = 1'b0;
                extra = 0;
            end else if (inflight) begin
                lat--;
                if (lat == 0) begin
                    tanh_done = 1'b1;
                    real_done = 1'b1;
                    tanh_out  = tanh_bits(op);
                    inflight  = 1'b0;
                    extra     = int'($urandom_range(0, 1));
                end
            end else if (extra != 0) begin
                tanh_done = 1'b1;          // stretched pulse
                extra = 0;
            end else if ($urandom_range(0, 15) == 0) begin
                tanh_done = 1'b1;          // stray pulse with garbage data
                tanh_out  = {$urandom, $urandom};
            end
        end
    end

    // ---------------- scoreboard / compare ----------------
    logic [64:0] iss_q [$];   // accepted, not yet issued
    logic [64:0] out_q [$];   // accepted, not yet delivered
    logic [63:0] got_d [$];
    logic        got_l [$];

    initial begin
        logic        hold_prev = 1'b0;
        logic [63:0] hold_data = '0;
        logic        hold_last = 1'b0;
        logic        vnext = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_in_ready",   in_ready == 1'b1,   64'(in_ready),   64'd1);
                chk("rst_out_valid",  out_valid == 1'b0,  64'(out_valid),  64'd0);
                chk("rst_tanh_start", tanh_start == 1'b0, 64'(tanh_start), 64'd0);
                chk("rst_busy",       busy == 1'b0,       64'(busy),       64'd0);
                chk("rst_fifo_count", fifo_count == '0,   64'(fifo_count), 64'd0);
                chk("rst_out_data",   out_data == '0,     out_data,        64'd0);
                chk("rst_tanh_in",    tanh_in == '0,      tanh_in,         64'd0);
                iss_q.delete();
                out_q.delete();
                hold_prev = 1'b0;
                vnext = 1'b0;
                continue;
            end
            chk("fifo_count", 64'(fifo_count) == 64'(iss_q.size()), 64'(fifo_count), 64'(iss_q.size()));
            chk("in_ready", in_ready == (iss_q.size() != DEPTH), 64'(in_ready), 64'(iss_q.size() != DEPTH));
            chk("busy", busy == (out_q.size() != 0), 64'(busy), 64'(out_q.size() != 0));
            if (vnext) chk("done_to_valid", out_valid, 64'(out_valid), 64'd1);
            if (hold_prev) begin
                chk("hold_valid", out_valid, 64'(out_valid), 64'd1);
                chk("hold_data",  out_data == hold_data, out_data, hold_data);
                chk("hold_last",  out_last == hold_last, 64'(out_last), 64'(hold_last));
            end
            if (out_valid) begin
                chk("result_pending", out_q.size() > iss_q.size(), 64'(out_q.size()), 64'(iss_q.size()));
                if (out_q.size() > iss_q.size()) begin
                    chk("out_data", out_data == tanh_bits(out_q[0][63:0]), out_data, tanh_bits(out_q[0][63:0]));
                    chk("out_last", out_last == out_q[0][64], 64'(out_last), 64'(out_q[0][64]));
                    if (out_ready) begin
                        void'(out_q.pop_front());
                        got_d.push_back(out_data);
                        got_l.push_back(out_last);
                    end
                end
            end
            if (tanh_start) begin
                chk("issue_pending", iss_q.size() != 0, 64'(iss_q.size()), 64'd1);
                if (iss_q.size() != 0) begin
                    chk("tanh_in", tanh_in == iss_q[0][63:0], tanh_in, iss_q[0][63:0]);
                    void'(iss_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                iss_q.push_back({in_last, in_data});
                out_q.push_back({in_last, in_data});
            end
            hold_prev = out_valid && !out_ready;
            hold_data = out_data;
            hold_last = out_last;
            vnext     = real_done;
        end
    end

    // ---------------- stimulus helpers (start and end at posedge+1) ----------------
    task automatic try_push(input logic [63:0] d, input logic l, input int maxc,
                            output bit ok, output int k);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        ok = 1'b0;
        k  = -1;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk); #1;
            if (ok) k = cyc;
        end
    endtask

    task automatic push(input logic [63:0] d, input logic l);
        bit ok;
        int k;
        try_push(d, l, 50, ok, k);
        chk("push_accepted", ok, 64'(ok), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        bit ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", ok, 64'(ok), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"},   in_ready == 1'b1,   64'(in_ready),   64'd1);
        chk({tag, "_out_valid"},  out_valid == 1'b0,  64'(out_valid),  64'd0);
        chk({tag, "_tanh_start"}, tanh_start == 1'b0, 64'(tanh_start), 64'd0);
        chk({tag, "_busy"},       busy == 1'b0,       64'(busy),       64'd0);
        chk({tag, "_fifo_count"}, fifo_count == '0,   64'(fifo_count), 64'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        bit ok;
        int k;
        int n0;
        int acc;
        real v4 [4];
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("idle");

        // single operand, start latency, hold without ready
        got_d.delete(); got_l.delete();
        n0 = n_starts;
        try_push($realtobits(-0.005), 1'b1, 10, ok, k);
        in_valid = 1'b0;
        chk("single_push", ok, 64'(ok), 64'd1);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = out_valid;
        end
        chk("single_out_valid", ok, 64'(ok), 64'd1);
        chk("single_start_count", n_starts == n0 + 1, 64'(n_starts - n0), 64'd1);
        chk("single_start_cycle", last_start_cyc == k + 1, 64'(last_start_cyc), 64'(k + 1));
        repeat (3) @(negedge clk);
        chk("single_held", out_valid, 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_idle(20);
        chk("single_n", got_d.size() == 1, 64'(got_d.size()), 64'd1);
        if (got_d.size() == 1) begin
            chk_real("single_value", got_d[0], -0.0049999583);
            chk("single_last", got_l[0] == 1'b1, 64'(got_l[0]), 64'd1);
        end

        // back-to-back vector with ready held high
        got_d.delete(); got_l.delete();
        push($realtobits(0.0), 1'b0);
        push($realtobits(0.5), 1'b0);
        push($realtobits(-1.0), 1'b0);
        push($realtobits(2.0), 1'b1);
        wait_idle(60);
        v4 = '{0.0, 0.4621171573, -0.7615941560, 0.9640275801};
        chk("vec_n", got_d.size() == 4, 64'(got_d.size()), 64'd4);
        if (got_d.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk_real($sformatf("vec_value%0d", i), got_d[i], v4[i]);
                chk($sformatf("vec_last%0d", i), got_l[i] == (i == 3), 64'(got_l[i]), 64'(i == 3));
            end
        end

        // fill to full with the output stalled, then push against the ISSUE pop
        got_d.delete(); got_l.delete();
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            try_push(rand_operand(), (i == DEPTH + 1), 6, ok, k);
            if (!ok) break;
            acc++;
        end
        chk("full_accepted", acc == DEPTH + 1, 64'(acc), 64'(DEPTH + 1));
        @(negedge clk);
        chk("full_count", 64'(fifo_count) == 64'(DEPTH), 64'(fifo_count), 64'(DEPTH));
        chk("full_in_ready", in_ready == 1'b0, 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(negedge clk);
            ok = tanh_start;
        end
        chk("full_issue_seen", ok, 64'(ok), 64'd1);
        chk("issue_count_full", 64'(fifo_count) == 64'(DEPTH), 64'(fifo_count), 64'(DEPTH));
        chk("issue_refuses_push", in_ready == 1'b0, 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("after_pop_count", 64'(fifo_count) == 64'(DEPTH - 1), 64'(fifo_count), 64'(DEPTH - 1));
        chk("after_pop_ready", in_ready == 1'b1, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_idle(200);
        chk("full_delivered", got_d.size() == DEPTH + 2, 64'(got_d.size()), 64'(DEPTH + 2));

        // reset while waiting on fp_tanh with three entries queued
        force_lat = 30;
        push($realtobits(0.25), 1'b0);
        push($realtobits(-0.75), 1'b0);
        push($realtobits(3.0), 1'b0);
        push($realtobits(1.5), 1'b1);
        @(negedge clk);
        chk("prerst_count", 64'(fifo_count) == 64'd3, 64'(fifo_count), 64'd3);
        chk("prerst_busy", busy == 1'b1, 64'(busy), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready",   in_ready == 1'b1,   64'(in_ready),   64'd1);
        chk("arst_out_valid",  out_valid == 1'b0,  64'(out_valid),  64'd0);
        chk("arst_tanh_start", tanh_start == 1'b0, 64'(tanh_start), 64'd0);
        chk("arst_busy",       busy == 1'b0,       64'(busy),       64'd0);
        chk("arst_fifo_count", fifo_count == '0,   64'(fifo_count), 64'd0);
        chk("arst_tanh_in",    tanh_in == '0,      tanh_in,         64'd0);
        chk("arst_out_data",   out_data == '0,     out_data,        64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        force_lat = 0;
        repeat (2) @(posedge clk);
        #1;
        check_idle("postrst");
        got_d.delete(); got_l.delete();
        push($realtobits(1.0), 1'b1);
        wait_idle(20);
        chk("postrst_n", got_d.size() == 1, 64'(got_d.size()), 64'd1);
        if (got_d.size() == 1) begin
            chk_real("postrst_value", got_d[0], 0.7615941560);
            chk("postrst_last", got_l[0] == 1'b1, 64'(got_l[0]), 64'd1);
        end

        // randomized traffic, varying ready pressure
        for (int ph = 0; ph < 6; ph++) begin
            int rp;
            rp = int'($urandom_range(1, 4));
            for (int c = 0; c < 500; c++) begin
                in_valid  = ($urandom_range(0, 2) != 0);
                in_data   = rand_operand();
                in_last   = ($urandom_range(0, 3) == 0);
                out_ready = ($urandom_range(0, 4) < rp);
                @(posedge clk); #1;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle(300);
        chk("final_queue_empty", out_q.size() == 0, 64'(out_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
